fetch_unit: RTL and testbench

//  Instruction fetch stage: owns PC, issues word fetches to instruction memory, buffers returned

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_queue.sv | 43 ++++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths, reset PC default and the fetch queue entry type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} with push, pop and whole-queue flush.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             din_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_q, wr_q;
  logic [CW-1:0]  count_q;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage owning the PC, one request in flight, queued words to decode
// and branch/jump redirects that flush the queue and drop the stale in-flight response.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_base,
  input  logic [XLEN-1:0]    redirect_imm,
  output logic               redirect_misaligned,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  input  logic               instr_ready
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, target;
  logic            out_q, out_d, drop_q, drop_d, mis_q;
  logic            accept, take, push, pop;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  assign target              = redirect_base + redirect_imm;
  assign imem_req_valid      = rst_n && !out_q && ((count + CW'(out_q)) < CW'(QDEPTH));
  assign imem_addr           = rst_n ? pc_q : '0;
  assign accept              = imem_req_valid && imem_req_ready;
  assign take                = imem_rsp_valid && out_q;
  assign push                = take && !drop_q && !redirect_valid;
  assign instr_valid         = count != '0;
  assign pop                 = instr_valid && instr_ready && !redirect_valid;
  assign instr               = head.instr;
  assign instr_pc            = head.pc;
  assign redirect_misaligned = mis_q;
  // A redirect marks the outstanding request stale unless its response lands this very cycle.
  always_comb begin
    pc_d   = redirect_valid ? {target[XLEN-1:2], 2'b00} : accept ? pc_q + XLEN'(4) : pc_q;
    out_d  = accept ? 1'b1 : take ? 1'b0 : out_q;
    drop_d = redirect_valid ? (accept || (out_q && !imem_rsp_valid)) : take ? 1'b0 : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_q    <= 1'b0;
      drop_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      mis_q    <= redirect_valid && (target[1:0] != 2'b00);
      if (accept) req_pc_q <= pc_q;
    end
  end
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   ('{pc: req_pc_q, instr: imem_rsp_data}),
    .head_o  (head),
    .count_o (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed phases plus random traffic checked against a transaction-level model.
module tb_fetch_unit;
  localparam int QDEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_base = '0, redirect_imm = '0;
  logic        redirect_misaligned, instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  int          errors = 0, checks = 0;
  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC, pend_pc = '0, pend_data = '0;
  logic        m_mis = 1'b0, pend = 1'b0, pend_stale = 1'b0, wrap_acc = 1'b0;
  int          lat = 0, lat_max = 0, rdy_pct = 100, irdy_pct = 100, redir_pct = 0;
  logic        force_redir = 1'b0;
  logic [31:0] f_base = '0, f_imm = '0;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .redirect_misaligned(redirect_misaligned),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    logic exp_req;
    @(negedge clk);
    exp_req = !pend && (mq.size() < QDEPTH);
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("instr", instr, mq[0].instr);
      chk("instr_pc", instr_pc, mq[0].pc);
    end
    chk("misaligned", redirect_misaligned, m_mis);
  endtask

  task automatic go();
    logic        acc, take;
    logic [31:0] tgt;
    imem_req_ready = $urandom_range(99, 0) < rdy_pct;
    imem_rsp_valid = pend ? (lat == 0) : ($urandom_range(7, 0) == 0);
    imem_rsp_data  = (pend && lat == 0) ? pend_data : $urandom;
    redirect_valid = force_redir || ($urandom_range(99, 0) < redir_pct);
    redirect_base  = force_redir ? f_base : ($urandom & 32'hFFFF_FFFC);
    redirect_imm   = force_redir ? f_imm : ($urandom & 32'hFFFF_FFFE);
    instr_ready    = $urandom_range(99, 0) < irdy_pct;
    force_redir    = 1'b0;
    acc  = !pend && (mq.size() < QDEPTH) && imem_req_ready;
    take = pend && imem_rsp_valid;
    tgt  = redirect_base + redirect_imm;
    m_mis = redirect_valid && (tgt[1:0] != 2'b00);
    if (redirect_valid) mq.delete();
    else if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
    if (take && !redirect_valid && !pend_stale) mq.push_back('{pc: pend_pc, instr: pend_data});
    if (take) pend = 1'b0;
    else if (pend) begin
      lat--;
      if (redirect_valid) pend_stale = 1'b1;
    end
    if (acc) begin
      pend       = 1'b1;
      pend_stale = redirect_valid;
      pend_pc    = m_pc;
      pend_data  = $urandom;
      lat        = $urandom_range(lat_max, 0);
      if (m_pc == 32'hFFFF_FFFC) wrap_acc = 1'b1;
    end
    m_pc = redirect_valid ? (tgt & 32'hFFFF_FFFC) : acc ? m_pc + 32'd4 : m_pc;
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      go();
    end
  endtask

  task automatic wait_head(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    tick();
    while (mq.size() == 0 && n < 30) begin
      go();
      tick();
      n++;
    end
    chk({tag, "_valid"}, instr_valid, 1);
    chk({tag, "_pc"}, instr_pc, exp_pc);
    go();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"}, imem_req_valid, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_ivalid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_ipc"}, instr_pc, 0);
    chk({tag, "_mis"}, redirect_misaligned, 0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_mis = 1'b0;
    pend = 1'b0;
    pend_stale = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    #2 rst_n = 1'b1;
    // Test 1: streaming fetch, one word every two cycles
    rdy_pct = 100; irdy_pct = 100; lat_max = 0; redir_pct = 0;
    tick();
    chk("t1_first_addr", imem_addr, RESET_PC);
    chk("t1_first_req", imem_req_valid, 1);
    go();
    cycle(16);
    // Test 2: decode stalled, queue fills, requests stop
    irdy_pct = 0;
    cycle(10);
    tick();
    chk("t2_req_blocked", imem_req_valid, 0);
    chk("t2_full", instr_valid, 1);
    go();
    irdy_pct = 100;
    cycle(10);
    // Test 3: redirect with a response outstanding and a non-empty queue
    irdy_pct = 0; lat_max = 2;
    n = 0;
    tick();
    while (!(pend && mq.size() != 0) && n < 30) begin
      go();
      tick();
      n++;
    end
    force_redir = 1'b1; f_base = 32'h0000_0100; f_imm = 32'hFFFF_FFF0;
    go();
    tick();
    chk("t3_flushed", instr_valid, 0);
    go();
    irdy_pct = 100;
    wait_head("t3", 32'h0000_00F0);
    // Test 4: misaligned target
    cycle(3);
    tick();
    force_redir = 1'b1; f_base = 32'h0000_0010; f_imm = 32'h0000_0006;
    go();
    tick();
    chk("t4_mis_pulse", redirect_misaligned, 1);
    chk("t4_addr", imem_addr, 32'h0000_0014);
    go();
    tick();
    chk("t4_mis_clear", redirect_misaligned, 0);
    go();
    wait_head("t4", 32'h0000_0014);
    // Test 5: PC wraps from the top of the address space
    lat_max = 0;
    tick();
    force_redir = 1'b1; f_base = 32'hFFFF_FFF0; f_imm = 32'h0000_000C;
    go();
    wrap_acc = 1'b0;
    n = 0;
    while (!wrap_acc && n < 30) begin
      cycle(1);
      n++;
    end
    tick();
    chk("t5_wrap_addr", imem_addr, 32'h0000_0000);
    go();
    wait_head("t5", 32'hFFFF_FFFC);
    // Random traffic
    rdy_pct = 70; irdy_pct = 60; redir_pct = 8; lat_max = 3;
    cycle(500);
    // Test 6: reset with a request in flight, response arrives during reset
    redir_pct = 0; rdy_pct = 100;
    n = 0;
    tick();
    while (!pend && n < 30) begin
      go();
      tick();
      n++;
    end
    chk("t6_inflight", imem_req_valid, 0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_checks("t6_rst");
    @(posedge clk);
    #1 imem_rsp_valid = 1'b1;
    imem_rsp_data = $urandom;
    @(negedge clk);
    reset_checks("t6_rsp");
    imem_rsp_valid = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    irdy_pct = 100; lat_max = 0;
    tick();
    chk("t6_first_addr", imem_addr, RESET_PC);
    chk("t6_first_req", imem_req_valid, 1);
    go();
    wait_head("t6", RESET_PC);
    cycle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
